ysyx_22041211_mem_arbiter: RTL and testbench

//  Shares the single data-memory port between IFU (read-only fetch) and LSU (load/store).

---
 rtl/ysyx_22041211_mem_arbiter_pkg.sv | 20 ++
 rtl/ysyx_22041211_mem_arbiter_rr_arbiter2.sv | 49 ++++
 rtl/ysyx_22041211_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ysyx_22041211_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU data-memory arbiter.
package ysyx_22041211_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IFU = 1'b0,
    ARB_OWN_LSU = 1'b1
  } arb_owner_e;

  // Byte mask covering a full 32-bit word; fetches always read whole words.
  localparam logic [7:0] MEM_MASK_32   = 8'h0F;
  localparam logic [7:0] MEM_MASK_NONE = 8'h00;

endpackage

// File: rtl/ysyx_22041211_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between IFU and LSU. last_grant only moves when
// the top actually accepts a request, so a tie always goes to whoever was
// not served last.
module ysyx_22041211_mem_arbiter_rr_arbiter2
  import ysyx_22041211_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic accept,
  output logic grant_ifu,
  output logic grant_lsu
);

  arb_owner_e last_grant_q;
  arb_owner_e last_grant_d;

  // Winner selection: single requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (ifu_valid && lsu_valid) begin
      grant_ifu = (last_grant_q == ARB_OWN_LSU);
      grant_lsu = (last_grant_q == ARB_OWN_IFU);
    end else begin
      grant_ifu = ifu_valid;
      grant_lsu = lsu_valid;
    end
  end

  // Remember the winner only on an actual accept.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = grant_ifu ? ARB_OWN_IFU : ARB_OWN_LSU;
    end
  end

  // last_grant register; reset favours IFU on the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= ARB_OWN_LSU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Shares the single data-memory port between IFU fetches and LSU loads/stores,
// one outstanding transaction at a time.
//
//   state | meaning
//   IDLE  | offer ready to the arbitration winner; accept latches owner+fields
//   ISSUE | mem_req_valid high until memory accepts
//   WAIT  | waiting for the memory response pulse, captured into owner's rdata
//   RESP  | owner's resp_valid high until the owner takes it
module ysyx_22041211_mem_arbiter
  import ysyx_22041211_mem_arbiter_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_LEN-1:0] ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_LEN-1:0] ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_LEN-1:0] lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_LEN-1:0] lsu_wdata,
  input  logic [7:0]          lsu_wmask,
  input  logic [7:0]          lsu_rmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_LEN-1:0] lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic [7:0]          mem_wmask,
  output logic [7:0]          mem_rmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  arb_state_e          state_q,     state_d;
  arb_owner_e          owner_q,     owner_d;
  logic [ADDR_LEN-1:0] addr_q,      addr_d;
  logic                wen_q,       wen_d;
  logic [DATA_LEN-1:0] wdata_q,     wdata_d;
  logic [7:0]          wmask_q,     wmask_d;
  logic [7:0]          rmask_q,     rmask_d;
  logic [DATA_LEN-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [DATA_LEN-1:0] lsu_rdata_q, lsu_rdata_d;

  logic grant_ifu;
  logic grant_lsu;
  logic accept;

  // Any valid request in IDLE is a handshake with the winner.
  assign accept = (state_q == ARB_IDLE) && (ifu_req_valid || lsu_req_valid);

  ysyx_22041211_mem_arbiter_rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .accept    (accept),
    .grant_ifu (grant_ifu),
    .grant_lsu (grant_lsu)
  );

  // Next-state, latched request fields and handshake outputs.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    rmask_d        = rmask_q;
    ifu_rdata_d    = ifu_rdata_q;
    lsu_rdata_d    = lsu_rdata_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
        if (grant_ifu) begin
          owner_d = ARB_OWN_IFU;
          addr_d  = ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = MEM_MASK_NONE;
          rmask_d = MEM_MASK_32;
          state_d = ARB_ISSUE;
        end else if (grant_lsu) begin
          owner_d = ARB_OWN_LSU;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          rmask_d = lsu_rmask;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_resp_valid) begin
          if (owner_q == ARB_OWN_IFU) begin
            ifu_rdata_d = mem_rdata;
          end else begin
            // stores report completion with zero data
            lsu_rdata_d = wen_q ? '0 : mem_rdata;
          end
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (owner_q == ARB_OWN_IFU) begin
          ifu_resp_valid = 1'b1;
          if (ifu_resp_ready) begin
            state_d = ARB_IDLE;
          end
        end else begin
          lsu_resp_valid = 1'b1;
          if (lsu_resp_ready) begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, owner, latched memory fields and per-owner read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_OWN_IFU;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rmask_q     <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rmask_q     <= rmask_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign mem_rmask = rmask_q;
  assign ifu_rdata = ifu_rdata_q;
  assign lsu_rdata = lsu_rdata_q;

  // A memory response outside WAIT has no transaction to belong to.
  a_resp_only_in_wait: assert property (
    @(posedge clk) disable iff (rst) mem_resp_valid |-> (state_q == ARB_WAIT)
  );

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter.
module tb_ysyx_22041211_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask, lsu_rmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask, mem_rmask;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_22041211_mem_arbiter #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_rmask(lsu_rmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rmask(mem_rmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ifu_req_valid = 0; ifu_resp_ready = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_resp_ready = 0; lsu_addr = 0; lsu_wen = 0;
    lsu_wdata = 0; lsu_wmask = 0; lsu_rmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_cmp++;
    if ({mem_req_valid, mem_wen, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {mem_req_valid, mem_wen, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_wmask, mem_rmask} !== 80'h0) begin
      n_err++;
      $display("FAIL reset_mem_fields: got %h want 0", {mem_addr, mem_wdata, mem_wmask, mem_rmask});
    end
    n_cmp++;
    if ({ifu_rdata, lsu_rdata} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h want 0", {ifu_rdata, lsu_rdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_ifu_fetch();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    #1;
    n_cmp++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL t1_ready: got %b want 10", {ifu_req_ready, lsu_req_ready});
    end
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    #1;
    n_cmp++;
    if ({mem_req_valid, mem_wen, mem_addr, mem_wmask, mem_rmask} !== {1'b1, 1'b0, 32'h8000_0000, 8'h00, 8'h0F}) begin
      n_err++;
      $display("FAIL t1_issue: got %b %b %h %h %h want 1 0 80000000 00 0f",
               mem_req_valid, mem_wen, mem_addr, mem_wmask, mem_rmask);
    end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    #1;
    n_cmp++;
    if ({mem_req_valid, ifu_resp_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL t1_wait: got %b want 00", {mem_req_valid, ifu_resp_valid});
    end
    tick();
    mem_resp_valid = 0; ifu_resp_ready = 1;
    #1;
    n_cmp++;
    if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {2'b10, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL t1_resp: got %b %b %h want 1 0 12345678", ifu_resp_valid, lsu_resp_valid, ifu_rdata);
    end
    tick();
    ifu_resp_ready = 0;
    #1;
    n_cmp++;
    if (ifu_resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL t1_resp_drop: got %b want 0", ifu_resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ifu;
    logic [31:0] exp_data;
    do_reset();
    ifu_addr = 32'h8000_0100; lsu_addr = 32'h8000_2000; lsu_wen = 0; lsu_rmask = 8'h0F;
    ifu_req_valid = 1; lsu_req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      exp_ifu  = (i % 2 == 0);
      exp_data = 32'hA000_0000 + 32'(i);
      #1;
      n_cmp++;
      if ({ifu_req_ready, lsu_req_ready} !== {exp_ifu, ~exp_ifu}) begin
        n_err++;
        $display("FAIL t2_grant%0d: got %b want %b", i, {ifu_req_ready, lsu_req_ready}, {exp_ifu, ~exp_ifu});
      end
      tick();
      mem_req_ready = 1;
      #1;
      n_cmp++;
      if (mem_addr !== (exp_ifu ? 32'h8000_0100 : 32'h8000_2000)) begin
        n_err++;
        $display("FAIL t2_addr%0d: got %h want %h", i, mem_addr, exp_ifu ? 32'h8000_0100 : 32'h8000_2000);
      end
      tick();
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = exp_data;
      tick();
      mem_resp_valid = 0; ifu_resp_ready = 1; lsu_resp_ready = 1;
      #1;
      n_cmp++;
      if ({ifu_resp_valid, lsu_resp_valid} !== {exp_ifu, ~exp_ifu}) begin
        n_err++;
        $display("FAIL t2_resp%0d: got %b want %b", i, {ifu_resp_valid, lsu_resp_valid}, {exp_ifu, ~exp_ifu});
      end
      n_cmp++;
      if ((exp_ifu ? ifu_rdata : lsu_rdata) !== exp_data) begin
        n_err++;
        $display("FAIL t2_rdata%0d: got %h want %h", i, exp_ifu ? ifu_rdata : lsu_rdata, exp_data);
      end
      tick();
      ifu_resp_ready = 0; lsu_resp_ready = 0;
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
  endtask

  task automatic test_store();
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1004;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F; lsu_rmask = 8'h00;
    #1;
    n_cmp++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL t3_ready: got %b want 01", {ifu_req_ready, lsu_req_ready});
    end
    tick();
    lsu_req_valid = 0; mem_req_ready = 1;
    #1;
    n_cmp++;
    if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== {2'b11, 32'h8000_1004, 32'hDEAD_BEEF, 8'h0F}) begin
      n_err++;
      $display("FAIL t3_issue: got %b %b %h %h %h want 1 1 80001004 deadbeef 0f",
               mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask);
    end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_resp_valid = 0; lsu_resp_ready = 1;
    #1;
    n_cmp++;
    if ({lsu_resp_valid, ifu_resp_valid, lsu_rdata} !== {2'b10, 32'h0}) begin
      n_err++;
      $display("FAIL t3_resp: got %b %b %h want 1 0 00000000", lsu_resp_valid, ifu_resp_valid, lsu_rdata);
    end
    tick();
    lsu_resp_ready = 0; lsu_wen = 0; lsu_wmask = 0; lsu_wdata = 0;
  endtask

  task automatic test_stalls();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
    lsu_addr = 32'h8000_3000; lsu_rmask = 8'h0F;
    #1;
    n_cmp++;
    if (ifu_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL t4_accept: got %b want 1", ifu_req_ready);
    end
    tick();
    ifu_req_valid = 0; lsu_req_valid = 1; mem_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({mem_req_valid, mem_addr, mem_rmask, lsu_req_ready} !== {1'b1, 32'h8000_0200, 8'h0F, 1'b0}) begin
        n_err++;
        $display("FAIL t4_stall%0d: got %b %h %h %b want 1 80000200 0f 0",
                 i, mem_req_valid, mem_addr, mem_rmask, lsu_req_ready);
      end
      tick();
    end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h55AA_55AA;
    #1;
    n_cmp++;
    if ({mem_req_valid, mem_addr, lsu_req_ready, ifu_resp_valid} !== {1'b0, 32'h8000_0200, 2'b00}) begin
      n_err++;
      $display("FAIL t4_wait: got %b %h %b %b want 0 80000200 0 0",
               mem_req_valid, mem_addr, lsu_req_ready, ifu_resp_valid);
    end
    tick();
    mem_resp_valid = 0; ifu_resp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({ifu_resp_valid, ifu_rdata, lsu_req_ready, mem_req_valid} !== {1'b1, 32'h55AA_55AA, 2'b00}) begin
        n_err++;
        $display("FAIL t4_hold%0d: got %b %h %b %b want 1 55aa55aa 0 0",
                 i, ifu_resp_valid, ifu_rdata, lsu_req_ready, mem_req_valid);
      end
      tick();
    end
    ifu_resp_ready = 1;
    tick();
    ifu_resp_ready = 0;
    #1;
    n_cmp++;
    if ({ifu_resp_valid, lsu_req_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL t4_release: got %b want 01", {ifu_resp_valid, lsu_req_ready});
    end
    lsu_req_valid = 0;
    tick();
  endtask

  task automatic test_rst_in_wait();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0300;
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    #1;
    n_cmp++;
    if (mem_addr !== 32'h8000_0300) begin
      n_err++;
      $display("FAIL t5_pre_addr: got %h want 80000300", mem_addr);
    end
    rst = 1; mem_resp_valid = 1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    rst = 0; mem_resp_valid = 0;
    #1;
    n_cmp++;
    if ({mem_req_valid, mem_wen, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 6'b0) begin
      n_err++;
      $display("FAIL t5_ctrl: got %b want 000000",
               {mem_req_valid, mem_wen, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_wmask, mem_rmask} !== 80'h0) begin
      n_err++;
      $display("FAIL t5_mem_fields: got %h want 0", {mem_addr, mem_wdata, mem_wmask, mem_rmask});
    end
    n_cmp++;
    if ({ifu_rdata, lsu_rdata} !== 64'h0) begin
      n_err++;
      $display("FAIL t5_rdata: got %h want 0", {ifu_rdata, lsu_rdata});
    end
    tick();
    ifu_req_valid = 1; lsu_req_valid = 1;
    #1;
    n_cmp++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL t5_tie: got %b want 10", {ifu_req_ready, lsu_req_ready});
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    tick();
  endtask

  task automatic test_lsu_load_blocks_ifu();
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_4001; lsu_rmask = 8'h01;
    #1;
    n_cmp++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL t6_accept: got %b want 01", {ifu_req_ready, lsu_req_ready});
    end
    tick();
    lsu_req_valid = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0400; mem_req_ready = 1;
    #1;
    n_cmp++;
    if ({mem_addr, mem_rmask, mem_wen, ifu_req_ready} !== {32'h8000_4001, 8'h01, 2'b00}) begin
      n_err++;
      $display("FAIL t6_issue: got %h %h %b %b want 80004001 01 0 0", mem_addr, mem_rmask, mem_wen, ifu_req_ready);
    end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_00C3;
    #1;
    n_cmp++;
    if (ifu_req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL t6_wait_ready: got %b want 0", ifu_req_ready);
    end
    tick();
    mem_resp_valid = 0; lsu_resp_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if ({lsu_resp_valid, lsu_rdata, ifu_req_ready, ifu_resp_valid} !== {1'b1, 32'h0000_00C3, 2'b00}) begin
        n_err++;
        $display("FAIL t6_hold%0d: got %b %h %b %b want 1 000000c3 0 0",
                 i, lsu_resp_valid, lsu_rdata, ifu_req_ready, ifu_resp_valid);
      end
      tick();
    end
    lsu_resp_ready = 1;
    tick();
    lsu_resp_ready = 0;
    #1;
    n_cmp++;
    if ({ifu_req_ready, lsu_resp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL t6_ifu_after: got %b want 10", {ifu_req_ready, lsu_resp_valid});
    end
    ifu_req_valid = 0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_ifu_fetch();
    test_back_to_back();
    test_store();
    test_stalls();
    test_rst_in_wait();
    test_lsu_load_blocks_ifu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
